gf180mcu_fd_sc_mcu9t5v0__evtcap_1: RTL and testbench
====================================================

# gf180mcu_fd_sc_mcu9t5v0__evtcap_1

Event-capture macro that sits directly downstream of the `or2` cell. It consumes the OR-combined event line `Z`, which is driven into `D` here. It synchronizes `D` to `CLK` and counts rising edges in a saturating accumulator. It then delivers counted batches to a slow consumer over a four-phase REQ/ACK handshake, so no event is lost while the consumer is busy.

## Interface
- `CNT_W`, default 8: width of the event accumulator and of `Q_CNT`; legal range 2..16.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `D`; legal range 2..4.
- `CLK` input 1: the single clock; all state is updated on its rising edge.
- `RN` input 1: reset, asynchronous and active-low. It clears all state immediately; release is synchronous to `CLK`.
- `D` input 1: asynchronous event line, driven by the `Z` output of the upstream `or2` cell.
- `ACK` input 1: consumer acknowledge, synchronous to `CLK`.
- `Q_REQ` output 1: batch-valid request.
- `Q_CNT` output `CNT_W`: snapshot of the edge count in the current batch.
- `Q_OVF` output 1: this batch saturated.

## Operation
- **Synchronizer chain.** The chain `s[0..SYNC_STAGES-1]` samples `D`. The register `prev` holds the last synchronized value. `edge = s_last & ~prev`.
- **Accumulator `acc`.**
  - On `edge`, `acc` increments by 1 and saturates at 2^CNT_W−1.
  - Reaching saturation sets the sticky `ovf_acc`.
  - Further edges while saturated are dropped.
- **States:** IDLE, REQ, WAIT_LO.
  - **IDLE:** when `acc != 0`:
    - `Q_CNT <= acc` and `Q_OVF <= ovf_acc`.
    - `acc` clears, `ovf_acc` clears, `Q_REQ <= 1`.
    - Go to REQ.
  - **REQ:** hold `Q_REQ`, `Q_CNT` and `Q_OVF` stable. When `ACK == 1`: `Q_REQ <= 0`, go to WAIT_LO.
  - **WAIT_LO:** when `ACK == 0`, go to IDLE. A new batch can launch one cycle later at the earliest.
- **Edges during REQ/WAIT_LO** keep accumulating into `acc` and form the next batch.
- **Edge in the snapshot cycle:** `acc` becomes 1 rather than 0, so the event is never lost. `ovf_acc` follows the same rule.
- **`ACK == 1` while in IDLE** is ignored. **`ACK` held high into IDLE** does not complete a handshake; REQ requires `ACK` to rise after `Q_REQ` rises.
- **`Q_CNT` and `Q_OVF`** retain their last values after `Q_REQ` falls and are only meaningful while `Q_REQ == 1`.
- **Reset mid-operation:** every register clears immediately, including an in-flight batch and `acc`. `Q_REQ` drops asynchronously. The state returns to IDLE.

## Timing
- Reset values: `Q_REQ` = 0, `Q_CNT` = 0, `Q_OVF` = 0, state IDLE, `acc` = 0, `ovf_acc` = 0, sync chain = 0, `prev` = 0.
- Let edge k be the first `CLK` edge that samples `D` high.
  - `edge` is asserted after edge k+SYNC_STAGES−1.
  - `acc` = 1 after edge k+SYNC_STAGES.
  - `Q_REQ` = 1 after edge k+SYNC_STAGES+1.
  - Default latency is therefore 3 cycles from `D` to `Q_REQ`.
- `ACK` to `Q_REQ` falling: 1 cycle.
- Minimum handshake period: 3 cycles, consisting of REQ→WAIT_LO→IDLE→REQ.
- `D` must stay low for at least 1 cycle, plus 1 more with the filter compiled in, between events for them to count separately.

## Configuration
- Macro: `GF180MCU_FD_SC_MCU9T5V0_EVTCAP_GLITCH_FILTER_EN`.
- **Defined:** one extra flop `f` follows `s_last`. The filtered level `prev_next` updates only when `s_last == f`, i.e. two consecutive equal samples. A single-cycle high pulse on the synchronized line produces no edge. All latencies grow by 1 cycle.
- **Undefined:** no filter; `edge` is taken directly from `s_last`, and the latencies are exactly as in Timing.

## Structure
- Shared package `gf180mcu_fd_sc_mcu9t5v0__evtcap_pkg` holds:
  - the state enum `evtcap_state_t` (IDLE=2'd0, REQ=2'd1, WAIT_LO=2'd2);
  - the localparams for legal `CNT_W`/`SYNC_STAGES` bounds.
- One sub-module, `gf180mcu_fd_sc_mcu9t5v0__evtcap_sync`.
  - It contains the parameterized synchronizer, the optional glitch filter and the edge detector.
  - Ports: `CLK`, `RN`, `D`, `EDGE`.
- The top level holds the accumulator, the FSM and the output registers.

## Test plan
- **Reset:** assert `RN` = 0 mid-REQ with `Q_CNT` = 5 → `Q_REQ`, `Q_CNT` and `Q_OVF` read 0 immediately; after release, no request without new edges.
- **Single event:** one `D` pulse 3 cycles wide, `ACK` tied low → `Q_REQ` rises 3 cycles after the sampling edge, with `Q_CNT` = 1 and `Q_OVF` = 0, and holds indefinitely.
- **Accumulation during handshake:**
  - Sequence: 4 pulses, then `ACK` delayed 20 cycles, then 6 more pulses.
  - Required: first batch `Q_CNT` = 4; after `ACK` falls, second batch `Q_CNT` = 6.
- **Snapshot collision:** an edge lands in the exact snapshot cycle → next batch has `Q_CNT` = 1 (no loss).
- **Saturation:** `CNT_W` = 2, 5 pulses with `ACK` low during launch → first batch has `Q_CNT` = 1; following batch has `Q_CNT` = 3 and `Q_OVF` = 1.
- **Filter, with macro defined:**
  - A 1-cycle synchronized pulse → no `Q_REQ`.
  - A 2-cycle pulse → `Q_CNT` = 1, with `Q_REQ` appearing 4 cycles after the sampling edge.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__evtcap_pkg.sv
// Shared types and bounds for the evtcap event-capture macro.
// Optional glitch filter: GF180MCU_FD_SC_MCU9T5V0_EVTCAP_GLITCH_FILTER_EN.
package gf180mcu_fd_sc_mcu9t5v0__evtcap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_LO = 2'd2
  } evtcap_state_t;

  localparam int unsigned CNT_W_MIN       = 2;
  localparam int unsigned CNT_W_MAX       = 16;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Keeps the synchronizer depth inside its legal range.
  function automatic int unsigned clamp_stages(input int unsigned n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__evtcap_sync.sv
// Synchronizer, optional two-sample glitch filter and rising-edge detector.
// Filter enabled by GF180MCU_FD_SC_MCU9T5V0_EVTCAP_GLITCH_FILTER_EN.
module gf180mcu_fd_sc_mcu9t5v0__evtcap_sync
  import gf180mcu_fd_sc_mcu9t5v0__evtcap_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RN,
  input  logic D,
  output logic EDGE
);

  localparam int unsigned STAGES = clamp_stages(SYNC_STAGES);

  logic [STAGES-1:0] s;
  logic              s_last;
  logic              prev;
  logic              prev_next;

  assign s_last = s[STAGES-1];

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) s <= '0;
    else     s <= {s[STAGES-2:0], D};
  end

`ifdef GF180MCU_FD_SC_MCU9T5V0_EVTCAP_GLITCH_FILTER_EN
  logic f;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) f <= 1'b0;
    else     f <= s_last;
  end

  // Level only moves after two consecutive equal samples.
  assign prev_next = (s_last == f) ? s_last : prev;
`else
  assign prev_next = s_last;
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) prev <= 1'b0;
    else     prev <= prev_next;
  end

  assign EDGE = prev_next & ~prev;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__evtcap_1.sv
// Event capture: counts synchronized rising edges of D and hands batches to a
// slow consumer over a four-phase REQ/ACK handshake.
// Optional glitch filter: GF180MCU_FD_SC_MCU9T5V0_EVTCAP_GLITCH_FILTER_EN.
module gf180mcu_fd_sc_mcu9t5v0__evtcap_1
  import gf180mcu_fd_sc_mcu9t5v0__evtcap_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             D,
  input  logic             ACK,
  output logic             Q_REQ,
  output logic [CNT_W-1:0] Q_CNT,
  output logic             Q_OVF
);

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  evtcap_state_t    state;
  evtcap_state_t    state_next;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_base;
  logic [CNT_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_acc;
  logic             ovf_base;
  logic             ovf_acc_next;
  logic             req_next;
  logic             ovf_next;
  logic             ack_q;
  logic             ack_rise;
  logic             edge_det;

  gf180mcu_fd_sc_mcu9t5v0__evtcap_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .RN  (RN),
    .D   (D),
    .EDGE(edge_det)
  );

  // A handshake completes only on an ACK that rises while REQ is pending.
  assign ack_rise = ACK & ~ack_q;

  always_comb begin
    state_next   = state;
    req_next     = Q_REQ;
    cnt_next     = Q_CNT;
    ovf_next     = Q_OVF;
    acc_base     = acc;
    ovf_base     = ovf_acc;
    acc_next     = acc;
    ovf_acc_next = ovf_acc;

    unique case (state)
      IDLE: begin
        if (acc != '0) begin
          cnt_next   = acc;
          ovf_next   = ovf_acc;
          req_next   = 1'b1;
          acc_base   = '0;
          ovf_base   = 1'b0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack_rise) begin
          req_next   = 1'b0;
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ACK) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Edges add onto the post-snapshot value so a colliding edge is kept.
    acc_next     = acc_base;
    ovf_acc_next = ovf_base;
    if (edge_det && (acc_base != ACC_MAX)) begin
      acc_next     = acc_base + CNT_W'(1);
      ovf_acc_next = ovf_base | (acc_next == ACC_MAX);
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state   <= IDLE;
      acc     <= '0;
      ovf_acc <= 1'b0;
      ack_q   <= 1'b0;
      Q_REQ   <= 1'b0;
      Q_CNT   <= '0;
      Q_OVF   <= 1'b0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      ovf_acc <= ovf_acc_next;
      ack_q   <= ACK;
      Q_REQ   <= req_next;
      Q_CNT   <= cnt_next;
      Q_OVF   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__evtcap_1.sv
// Bench for evtcap: directed scenarios plus random D/ACK traffic on an 8-bit
// and a 2-bit instance, checked against a batch-level event model.
module tb_gf180mcu_fd_sc_mcu9t5v0__evtcap_1;

  localparam int SS = 2;
  localparam int NI = 2;
`ifdef GF180MCU_FD_SC_MCU9T5V0_EVTCAP_GLITCH_FILTER_EN
  localparam int LAT_ACC = SS + 1;
`else
  localparam int LAT_ACC = SS;
`endif
  localparam int LAT_REQ = LAT_ACC + 1;

  logic       clk = 1'b0;
  logic       rn;
  logic       d;
  logic [1:0] ack;
  logic       req8, ovf8, req2, ovf2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__evtcap_1 #(.CNT_W(8), .SYNC_STAGES(SS)) u_w8 (
    .CLK(clk), .RN(rn), .D(d), .ACK(ack[0]),
    .Q_REQ(req8), .Q_CNT(cnt8), .Q_OVF(ovf8)
  );

  gf180mcu_fd_sc_mcu9t5v0__evtcap_1 #(.CNT_W(2), .SYNC_STAGES(SS)) u_w2 (
    .CLK(clk), .RN(rn), .D(d), .ACK(ack[1]),
    .Q_REQ(req2), .Q_CNT(cnt2), .Q_OVF(ovf2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit auto_ack = 1'b0;

  // Model: arrival cycle of each counted event, and a per-instance batch cursor.
  int ev_q[$];
  int head[NI];
  bit prev_d, level;
  bit busy[NI], waitlo[NI], ack_prev[NI], exp_req[NI], exp_ovf[NI];
  int exp_cnt[NI], idle_from[NI];
  int cnt_max[NI] = '{255, 3};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    ev_q.delete();
    prev_d = 1'b0;
    level  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      head[i] = 0; busy[i] = 1'b0; waitlo[i] = 1'b0; ack_prev[i] = 1'b0;
      exp_req[i] = 1'b0; exp_cnt[i] = 0; exp_ovf[i] = 1'b0; idle_from[i] = 0;
    end
  endtask

  // Advance the model by one clock edge given the D sample at that edge.
  task automatic model_step(input bit dv);
    bit stable;
    int n;
`ifdef GF180MCU_FD_SC_MCU9T5V0_EVTCAP_GLITCH_FILTER_EN
    stable = (dv == prev_d);
`else
    stable = 1'b1;
`endif
    if (stable && (dv != level)) begin
      if (dv) ev_q.push_back(cyc + SS);
      level = dv;
    end
    prev_d = dv;
    for (int i = 0; i < NI; i++) begin
      if (!busy[i]) begin
        if (cyc >= idle_from[i] && head[i] < ev_q.size() && ev_q[head[i]] < cyc) begin
          n = 0;
          while (head[i] < ev_q.size() && ev_q[head[i]] < cyc) begin
            n++;
            head[i]++;
          end
          exp_cnt[i] = (n > cnt_max[i]) ? cnt_max[i] : n;
          exp_ovf[i] = (n >= cnt_max[i]);
          exp_req[i] = 1'b1;
          busy[i]    = 1'b1;
          waitlo[i]  = 1'b0;
        end
      end else if (!waitlo[i]) begin
        if (ack[i] && !ack_prev[i]) begin
          exp_req[i] = 1'b0;
          waitlo[i]  = 1'b1;
        end
      end else if (!ack[i]) begin
        busy[i]      = 1'b0;
        idle_from[i] = cyc + 1;
      end
      ack_prev[i] = ack[i];
    end
  endtask

  task automatic compare_all();
    check("req_w8", int'(req8), int'(exp_req[0]));
    check("cnt_w8", int'(cnt8), exp_cnt[0]);
    check("ovf_w8", int'(ovf8), int'(exp_ovf[0]));
    check("req_w2", int'(req2), int'(exp_req[1]));
    check("cnt_w2", int'(cnt2), exp_cnt[1]);
    check("ovf_w2", int'(ovf2), int'(exp_ovf[1]));
  endtask

  // Random consumer: slow ACK responses plus occasional spurious ACKs.
  task automatic drive_acks();
    logic [1:0] obs;
    obs = {req2, req8};
    for (int i = 0; i < NI; i++) begin
      if (ack[i]) begin
        if ($urandom_range(0, 7) < 3) ack[i] = 1'b0;
      end else if (obs[i]) begin
        if ($urandom_range(0, 7) < 3) ack[i] = 1'b1;
      end else if ($urandom_range(0, 31) == 0) begin
        ack[i] = 1'b1;
      end
    end
  endtask

  task automatic tick(input bit dv);
    if (auto_ack) drive_acks();
    d = dv;
    @(posedge clk);
    cyc++;
    model_step(dv);
    #1;
    compare_all();
  endtask

  task automatic pulses(input int n, input int w, input int gap);
    for (int p = 0; p < n; p++) begin
      repeat (w) tick(1'b1);
      repeat (gap) tick(1'b0);
    end
  endtask

  task automatic handshake();
    ack = 2'b11;
    tick(1'b0);
    ack = 2'b00;
    tick(1'b0);
  endtask

  task automatic wait_req(input string tag);
    for (int j = 0; j < 40 && !(req8 && req2); j++) tick(1'b0);
    check(tag, int'(req8 & req2), 1);
  endtask

  initial begin
    int k;
    int rise;
    bit rd;
    rn  = 1'b0;
    d   = 1'b0;
    ack = 2'b00;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rn = 1'b1;
    repeat (3) tick(1'b0);

`ifdef GF180MCU_FD_SC_MCU9T5V0_EVTCAP_GLITCH_FILTER_EN
    tick(1'b1);
    repeat (12) tick(1'b0);
    check("filt_glitch_req", int'(req8), 0);
    k = cyc + 1;
    rise = -1;
    for (int j = 0; j < 12; j++) begin
      tick(j < 2);
      if (req8 && rise < 0) rise = cyc;
    end
    check("filt_latency", rise - k, LAT_REQ);
    check("filt_cnt", int'(cnt8), 1);
    handshake();
    repeat (4) tick(1'b0);
`endif

    // Single 3-cycle pulse, ACK low: request appears and holds.
    k = cyc + 1;
    rise = -1;
    for (int j = 0; j < 30; j++) begin
      tick(j < 3);
      if (req8 && rise < 0) rise = cyc;
    end
    check("single_latency", rise - k, LAT_REQ);
    check("single_cnt", int'(cnt8), 1);
    check("single_ovf", int'(ovf8), 0);
    check("single_hold", int'(req8), 1);

    // Four pulses behind a pending batch, then six more behind that.
    pulses(4, 2, 2);
    repeat (20) tick(1'b0);
    handshake();
    wait_req("acc_batch4_req");
    check("acc_batch4_cnt", int'(cnt8), 4);
    check("acc_batch4_ovf", int'(ovf8), 0);
    check("sat_w2_cnt", int'(cnt2), 3);
    check("sat_w2_ovf", int'(ovf2), 1);
    pulses(6, 2, 2);
    repeat (20) tick(1'b0);
    handshake();
    wait_req("acc_batch6_req");
    check("acc_batch6_cnt", int'(cnt8), 6);

    // Edge arriving in the exact snapshot cycle goes to the next batch.
    for (int j = 1; j <= 14; j++) begin
      ack = (j == 10) ? 2'b11 : 2'b00;
      tick(j == 1 || j == 2 || j == 12 - LAT_ACC || j == 13 - LAT_ACC);
      if (j == 12) begin
        check("coll_launch_req", int'(req8), 1);
        check("coll_launch_cnt", int'(cnt8), 1);
      end
    end
    handshake();
    wait_req("coll_next_req");
    check("coll_next_cnt", int'(cnt8), 1);

    // Reset in the middle of a five-event request.
    pulses(5, 2, 2);
    repeat (5) tick(1'b0);
    handshake();
    wait_req("rst_pre_req");
    check("rst_pre_cnt", int'(cnt8), 5);
    #3;
    rn = 1'b0;
    #1;
    check("rst_req", int'(req8), 0);
    check("rst_cnt", int'(cnt8), 0);
    check("rst_ovf", int'(ovf8), 0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rn = 1'b1;
    repeat (10) tick(1'b0);
    check("rst_no_req", int'(req8 | req2), 0);

    // Random D levels and consumer behaviour.
    auto_ack = 1'b1;
    rd = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 2) == 0) rd = ~rd;
      tick(rd);
    end
    repeat (80) tick(1'b0);
    auto_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
